// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the fval/lval/dval video link.
package frame_pkg;

  localparam int unsigned CHECKSUM_W = 16;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    FRAME,
    LINE,
    DONE
  } state_t;

endpackage

// File: rtl/frame_rx_stats.sv
// Per-frame pixel statistics: count, checksum, min and max, latched on request.
module frame_rx_stats
  import frame_pkg::*;
#(
  parameter int unsigned BPP   = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  valid,
  input  logic                  latch,
  input  logic [BPP-1:0]        pix_data,
  output logic [CNT_W-1:0]      pix_count,
  output logic [CHECKSUM_W-1:0] checksum,
  output logic [BPP-1:0]        pix_min,
  output logic [BPP-1:0]        pix_max
);

  logic [CNT_W-1:0]      pix_acc;
  logic [CHECKSUM_W-1:0] sum_acc;
  logic [BPP-1:0]        min_acc;
  logic [BPP-1:0]        max_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_acc   <= '0;
      sum_acc   <= '0;
      min_acc   <= '0;
      max_acc   <= '0;
      pix_count <= '0;
      checksum  <= '0;
      pix_min   <= '0;
      pix_max   <= '0;
    end else begin
      if (clear) begin
        pix_acc <= '0;
        sum_acc <= '0;
        min_acc <= '1;
        max_acc <= '0;
      end else if (valid) begin
        if (pix_acc != '1) pix_acc <= pix_acc + CNT_W'(1);
        sum_acc <= sum_acc + CHECKSUM_W'(pix_data);
        if (pix_data < min_acc) min_acc <= pix_data;
        if (pix_data > max_acc) max_acc <= pix_data;
      end
      // Results hold until the next completed frame.
      if (latch) begin
        pix_count <= pix_acc;
        checksum  <= sum_acc;
        pix_min   <= min_acc;
        pix_max   <= max_acc;
      end
    end
  end

endmodule

// File: rtl/frame_rx.sv
// Video link receiver: tracks frame/line framing, checks geometry and
// protocol, and reports per-frame statistics one cycle after fval falls.
module frame_rx
  import frame_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned BPP    = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fval,
  input  logic                  lval,
  input  logic                  dval,
  input  logic [BPP-1:0]        pix_data,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic                  err_width,
  output logic                  err_height,
  output logic                  err_proto,
  output logic [CNT_W-1:0]      line_count,
  output logic [CNT_W-1:0]      pix_count,
  output logic [CHECKSUM_W-1:0] checksum,
  output logic [BPP-1:0]        pix_min,
  output logic [BPP-1:0]        pix_max,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] HEIGHT_C = CNT_W'(HEIGHT);

  state_t           state, state_d;
  logic             fval_q, lval_q;
  logic [CNT_W-1:0] col_cnt, col_d;
  logic [CNT_W-1:0] line_acc, line_d;
  logic             werr, werr_d;
  logic             perr, perr_d;

  logic fval_rise_c, fval_fall_c, lval_rise_c, lval_fall_c;
  logic pix_valid_c, proto_err_c, line_bad_c, herr_c;
  logic stats_clear_c, stats_valid_c, stats_latch_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign fval_rise_c = fval & ~fval_q;
  assign fval_fall_c = ~fval & fval_q;
  assign lval_rise_c = lval & ~lval_q;
  assign lval_fall_c = ~lval & lval_q;
  assign pix_valid_c = fval & lval & dval;
  assign proto_err_c = (dval & ~lval) | (lval & ~fval);
  // A saturated counter can never be trusted as a correct size.
  assign line_bad_c  = (col_cnt != WIDTH_C) || (col_cnt == CNT_MAX);
  assign herr_c      = (line_acc != HEIGHT_C) || (line_acc == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYNC;
      fval_q   <= 1'b0;
      lval_q   <= 1'b0;
      col_cnt  <= '0;
      line_acc <= '0;
      werr     <= 1'b0;
      perr     <= 1'b0;
    end else begin
      state    <= state_d;
      fval_q   <= fval;
      lval_q   <= lval;
      col_cnt  <= col_d;
      line_acc <= line_d;
      werr     <= werr_d;
      perr     <= perr_d;
    end
  end

  always_comb begin
    state_d       = state;
    col_d         = col_cnt;
    line_d        = line_acc;
    werr_d        = werr;
    perr_d        = perr;
    stats_clear_c = 1'b0;
    stats_valid_c = 1'b0;
    stats_latch_c = 1'b0;
    case (state)
      SYNC: begin
        if (en && !fval) state_d = IDLE;
      end
      IDLE: begin
        if (!en) begin
          state_d = SYNC;
        end else if (fval_rise_c) begin
          state_d       = FRAME;
          stats_clear_c = 1'b1;
          col_d         = '0;
          line_d        = '0;
          werr_d        = 1'b0;
          perr_d        = 1'b0;
        end
      end
      FRAME: begin
        if (!en) begin
          state_d = SYNC;
        end else begin
          if (proto_err_c) perr_d = 1'b1;
          if (fval_fall_c) begin
            state_d = DONE;
          end else if (lval_rise_c) begin
            state_d       = LINE;
            col_d         = CNT_W'(pix_valid_c);
            stats_valid_c = pix_valid_c;
          end
        end
      end
      LINE: begin
        if (!en) begin
          state_d = SYNC;
        end else begin
          if (proto_err_c) perr_d = 1'b1;
          // fval dropping with the line still open closes that line too.
          if (fval_fall_c || lval_fall_c) begin
            line_d = sat_inc(line_acc);
            if (line_bad_c) werr_d = 1'b1;
            state_d = fval_fall_c ? DONE : FRAME;
          end else if (pix_valid_c) begin
            stats_valid_c = 1'b1;
            col_d         = sat_inc(col_cnt);
          end
        end
      end
      DONE: begin
        stats_latch_c = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_width  <= 1'b0;
      err_height <= 1'b0;
      err_proto  <= 1'b0;
      line_count <= '0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= stats_latch_c;
      if (stats_latch_c) begin
        frame_ok   <= ~(werr | herr_c | perr);
        err_width  <= werr;
        err_height <= herr_c;
        err_proto  <= perr;
        line_count <= line_acc;
        frame_cnt  <= frame_cnt + CNT_W'(1);
      end
    end
  end

  frame_rx_stats #(
    .BPP   (BPP),
    .CNT_W (CNT_W)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .clear     (stats_clear_c),
    .valid     (stats_valid_c),
    .latch     (stats_latch_c),
    .pix_data  (pix_data),
    .pix_count (pix_count),
    .checksum  (checksum),
    .pix_min   (pix_min),
    .pix_max   (pix_max)
  );

endmodule

// File: tb/tb_frame_rx.sv
// Bench for frame_rx: table of directed frames, randomized frames against a
// frame-level model, and hand sequences for enable and reset corner cases.
module tb_frame_rx;

  localparam int unsigned W     = 8;
  localparam int unsigned H     = 4;
  localparam int unsigned BPP   = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, en, fval, lval, dval;
  logic [BPP-1:0]   pix_data;
  logic             frame_done, frame_ok, err_width, err_height, err_proto;
  logic [CNT_W-1:0] line_count, pix_count, frame_cnt;
  logic [15:0]      checksum;
  logic [BPP-1:0]   pix_min, pix_max;

  always #5 clk = ~clk;

  frame_rx #(.WIDTH(W), .HEIGHT(H), .BPP(BPP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .fval(fval), .lval(lval), .dval(dval),
    .pix_data(pix_data), .frame_done(frame_done), .frame_ok(frame_ok),
    .err_width(err_width), .err_height(err_height), .err_proto(err_proto),
    .line_count(line_count), .pix_count(pix_count), .checksum(checksum),
    .pix_min(pix_min), .pix_max(pix_max), .frame_cnt(frame_cnt)
  );

  typedef struct {
    bit ok, werr, herr, perr;
    int lines, pix, csum, mn, mx;
  } exp_t;

  typedef struct {
    string name;
    int    nlines;
    int    short_line;
    int    short_len;
    int    fill;      // -1: pixel value equals its column
    bit    proto;
    exp_t  exp;
  } vec_t;

  // Frame under construction: line lengths and pixel values.
  int         n_lines;
  int         len_mem [0:7];
  logic [7:0] pix_mem [0:7][0:15];
  bit         inject;
  int         en_line   = -1;
  int         drop_line = -1;
  int         rst_line  = -1;

  int total = 0;
  int passed = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk($sformatf("%s.frame_done", tag), int'(frame_done), 0);
    chk($sformatf("%s.frame_ok", tag), int'(frame_ok), 0);
    chk($sformatf("%s.err_height", tag), int'(err_height), 0);
    chk($sformatf("%s.line_count", tag), int'(line_count), 0);
    chk($sformatf("%s.pix_count", tag), int'(pix_count), 0);
    chk($sformatf("%s.checksum", tag), int'(checksum), 0);
    chk($sformatf("%s.pix_max", tag), int'(pix_max), 0);
    chk($sformatf("%s.frame_cnt", tag), int'(frame_cnt), 0);
    exp_cnt = 0;
  endtask

  task automatic send_frame();
    fval = 1'b1;
    tick();
    tick();
    for (int l = 0; l < n_lines; l++) begin
      for (int c = 0; c < len_mem[l]; c++) begin
        lval = 1'b1; dval = 1'b1; pix_data = pix_mem[l][c];
        if (l == en_line && c == 4) en = 1'b1;
        if (l == drop_line && c == 2) en = 1'b0;
        if (l == rst_line && c == 3) rst = 1'b1;
        tick();
        if (rst) begin
          rst = 1'b0;
          check_zero("mid_rst");
        end
      end
      lval = 1'b0; dval = 1'b0; pix_data = '0;
      tick();
      if (inject && l == 0) begin
        dval = 1'b1; pix_data = 8'h55;
        tick();
        dval = 1'b0; pix_data = '0;
      end
      tick();
    end
    fval = 1'b0;
    tick();
  endtask

  task automatic expect_no_done(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (frame_done) seen++;
    end
    chk(name, seen, 0);
  endtask

  task automatic check_frame(input string tag, input exp_t e);
    int lat = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (frame_done) begin
        lat = i;
        break;
      end
    end
    chk($sformatf("%s.latency", tag), lat, 1);
    exp_cnt++;
    chk($sformatf("%s.frame_ok", tag), int'(frame_ok), int'(e.ok));
    chk($sformatf("%s.err_width", tag), int'(err_width), int'(e.werr));
    chk($sformatf("%s.err_height", tag), int'(err_height), int'(e.herr));
    chk($sformatf("%s.err_proto", tag), int'(err_proto), int'(e.perr));
    chk($sformatf("%s.line_count", tag), int'(line_count), e.lines);
    chk($sformatf("%s.pix_count", tag), int'(pix_count), e.pix);
    chk($sformatf("%s.checksum", tag), int'(checksum), e.csum);
    chk($sformatf("%s.pix_min", tag), int'(pix_min), e.mn);
    chk($sformatf("%s.pix_max", tag), int'(pix_max), e.mx);
    chk($sformatf("%s.frame_cnt", tag), int'(frame_cnt), exp_cnt % 65536);
    tick();
    chk($sformatf("%s.pulse_end", tag), int'(frame_done), 0);
  endtask

  task automatic load_vec(input vec_t v);
    n_lines = v.nlines;
    inject  = v.proto;
    for (int l = 0; l < 8; l++) begin
      len_mem[l] = (l == v.short_line) ? v.short_len : int'(W);
      for (int c = 0; c < 16; c++)
        pix_mem[l][c] = (v.fill < 0) ? 8'(c) : 8'(v.fill);
    end
  endtask

  // Frame-level reference: statistics straight from the line/pixel lists.
  function automatic exp_t model();
    exp_t e;
    e.lines = n_lines;
    e.pix = 0; e.csum = 0; e.mn = 255; e.mx = 0; e.werr = 1'b0;
    for (int l = 0; l < n_lines; l++) begin
      if (len_mem[l] != int'(W)) e.werr = 1'b1;
      for (int c = 0; c < len_mem[l]; c++) begin
        e.pix++;
        e.csum = (e.csum + int'(pix_mem[l][c])) % 65536;
        if (int'(pix_mem[l][c]) < e.mn) e.mn = int'(pix_mem[l][c]);
        if (int'(pix_mem[l][c]) > e.mx) e.mx = int'(pix_mem[l][c]);
      end
    end
    e.herr = (n_lines != int'(H));
    e.perr = inject;
    e.ok   = !(e.werr || e.herr || e.perr);
    return e;
  endfunction

  vec_t vecs [5];
  exp_t last;

  initial begin
    vecs[0] = '{"good",  4, -1, 0, -1,  1'b0, '{1'b1, 1'b0, 1'b0, 1'b0, 4, 32, 112, 0, 7}};
    vecs[1] = '{"short", 4,  1, 7, 255, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b0, 4, 31, 7905, 255, 255}};
    vecs[2] = '{"tall",  5, -1, 0, -1,  1'b0, '{1'b0, 1'b0, 1'b1, 1'b0, 5, 40, 140, 0, 7}};
    vecs[3] = '{"proto", 4, -1, 0, -1,  1'b1, '{1'b0, 1'b0, 1'b0, 1'b1, 4, 32, 112, 0, 7}};
    vecs[4] = '{"empty", 0, -1, 0, -1,  1'b0, '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 255, 0}};

    rst = 1'b1; en = 1'b0; fval = 1'b0; lval = 1'b0; dval = 1'b0; pix_data = '0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Enable arrives mid-frame: that frame is skipped, the next is reported.
    load_vec(vecs[0]);
    en_line = 1;
    send_frame();
    en_line = -1;
    expect_no_done("en_mid.no_done", 4);
    send_frame();
    check_frame("en_mid.next", vecs[0].exp);

    // Reset mid-frame: outputs clear, rest of frame ignored.
    tick();
    rst_line = 2;
    send_frame();
    rst_line = -1;
    expect_no_done("rst_mid.no_done", 4);
    send_frame();
    check_frame("rst_mid.next", vecs[0].exp);

    foreach (vecs[i]) begin
      load_vec(vecs[i]);
      send_frame();
      check_frame(vecs[i].name, vecs[i].exp);
    end

    for (int f = 0; f < 20; f++) begin
      n_lines = int'($urandom_range(3, 5));
      inject  = ($urandom_range(0, 3) == 0);
      for (int l = 0; l < 8; l++) begin
        len_mem[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(7, 9)) : int'(W);
        for (int c = 0; c < 16; c++) pix_mem[l][c] = 8'($urandom);
      end
      last = model();
      send_frame();
      check_frame($sformatf("rand%0d", f), last);
    end

    // Enable dropped mid-line: no report, previous results hold.
    load_vec(vecs[0]);
    drop_line = 1;
    send_frame();
    drop_line = -1;
    expect_no_done("en_drop.no_done", 4);
    chk("en_drop.checksum_hold", int'(checksum), last.csum);
    chk("en_drop.line_count_hold", int'(line_count), last.lines);
    en = 1'b1;
    tick();
    tick();
    send_frame();
    check_frame("en_drop.next", vecs[0].exp);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
